// File: rtl/signed_narrow_unit.sv
// Narrows signed WIDE-bit words to NARROW bits, saturating or wrapping on overflow; 2 registered stages, 1 word/clk.
// Valid/ready at both ends; the input side stalls only when both stages are full and the output is blocked.
module signed_narrow_unit #(
   parameter int WIDE   = 32,
   parameter int NARROW = 16,
   parameter int CNT_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [WIDE-1:0]   i_data_in,
   input  logic              i_mode,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [NARROW-1:0] o_data_out,
   output logic              o_ovf,
   output logic              o_ovf_sticky,
   output logic [CNT_W-1:0]  o_ovf_count,
   input  logic              i_clear_stats
);

   localparam logic [NARROW-1:0] SMAX = {1'b0, {(NARROW-1){1'b1}}};
   localparam logic [NARROW-1:0] SMIN = {1'b1, {(NARROW-1){1'b0}}};

   logic                   r_s1_vld;
   logic [WIDE-1:0]        r_s1_dat;
   logic                   r_s1_mode;
   logic                   r_s2_vld;
   logic [NARROW-1:0]      r_s2_dat;
   logic                   r_s2_ovf;
   logic                   r_ovf_sticky;
   logic [CNT_W-1:0]       r_ovf_count;

   logic [WIDE-NARROW:0]   w_s1_hi;
   logic                   w_s1_fit;
   logic [NARROW-1:0]      w_s1_res;
   logic                   w_s2_load;
   logic                   w_s1_load;
   logic                   w_out_xfer;

   // A value fits when every bit from the top down to the narrow sign bit agrees.
   assign w_s1_hi  = r_s1_dat[WIDE-1:NARROW-1];
   assign w_s1_fit = (&w_s1_hi) | ~(|w_s1_hi);

   always_comb begin
      w_s1_res = r_s1_dat[NARROW-1:0];
      if (!w_s1_fit && !r_s1_mode) begin
         w_s1_res = r_s1_dat[WIDE-1] ? SMIN : SMAX;
      end
   end

   assign w_s2_load  = ~r_s2_vld | i_out_ready;
   assign w_s1_load  = ~r_s1_vld | w_s2_load;
   assign w_out_xfer = r_s2_vld & i_out_ready;

   assign o_in_ready   = w_s1_load;
   assign o_out_valid  = r_s2_vld;
   assign o_data_out   = r_s2_dat;
   assign o_ovf        = r_s2_ovf;
   assign o_ovf_sticky = r_ovf_sticky;
   assign o_ovf_count  = r_ovf_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_dat  <= '0;
         r_s1_mode <= 1'b0;
      end else if (w_s1_load) begin
         r_s1_vld <= i_in_valid;
         if (i_in_valid) begin
            r_s1_dat  <= i_data_in;
            r_s1_mode <= i_mode;
         end
      end
   end

   // The output register only reloads when empty or draining, so held words stay stable.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s2_vld <= 1'b0;
         r_s2_dat <= '0;
         r_s2_ovf <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_dat <= w_s1_res;
            r_s2_ovf <= ~w_s1_fit;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ovf_sticky <= 1'b0;
         r_ovf_count  <= '0;
      end else if (i_clear_stats) begin
         r_ovf_sticky <= 1'b0;
         r_ovf_count  <= '0;
      end else if (w_out_xfer && r_s2_ovf) begin
         r_ovf_sticky <= 1'b1;
         if (r_ovf_count != {CNT_W{1'b1}}) begin
            r_ovf_count <= r_ovf_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_signed_narrow_unit.sv
// Bench for signed_narrow_unit: arithmetic reference model with an in-flight queue, checked every cycle on the falling edge.
module tb_signed_narrow_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_in_valid = 1'b0;
   logic        o_in_ready;
   logic [31:0] i_data_in = '0;
   logic        i_mode = 1'b0;
   logic        o_out_valid;
   logic        i_out_ready = 1'b1;
   logic [15:0] o_data_out;
   logic        o_ovf;
   logic        o_ovf_sticky;
   logic [7:0]  o_ovf_count;
   logic        i_clear_stats = 1'b0;

   signed_narrow_unit #(.WIDE(32), .NARROW(16), .CNT_W(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_in_valid   (i_in_valid),
      .o_in_ready   (o_in_ready),
      .i_data_in    (i_data_in),
      .i_mode       (i_mode),
      .o_out_valid  (o_out_valid),
      .i_out_ready  (i_out_ready),
      .o_data_out   (o_data_out),
      .o_ovf        (o_ovf),
      .o_ovf_sticky (o_ovf_sticky),
      .o_ovf_count  (o_ovf_count),
      .i_clear_stats(i_clear_stats)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] dat;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t        q[$];
   logic [16:0] obs[$];
   int          in_edges[$];
   int          out_edges[$];
   int          edge_cnt = 0;
   int          in_fires = 0;
   logic        m_sticky = 1'b0;
   int          m_count = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: compare the signed value against the 16-bit signed range.
   function automatic logic [16:0] model(input logic [31:0] d, input logic m);
      longint v;
      v = longint'($signed(d));
      if (v > 32767)       return m ? {1'b1, d[15:0]} : {1'b1, 16'h7FFF};
      else if (v < -32768) return m ? {1'b1, d[15:0]} : {1'b1, 16'h8000};
      else                 return {1'b0, d[15:0]};
   endfunction

   always @(posedge clk) edge_cnt = edge_cnt + 1;

   exp_t        f;
   logic        exp_vld;
   logic        fired;
   logic        fired_ovf;
   logic [16:0] mr;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_sticky = 1'b0;
         m_count  = 0;
         chk("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
         chk("rst_data_out", {16'd0, o_data_out}, 32'd0);
         chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
         chk("rst_sticky", {31'd0, o_ovf_sticky}, 32'd0);
         chk("rst_count", {24'd0, o_ovf_count}, 32'd0);
      end else begin
         exp_vld = (q.size() > 0) && (edge_cnt >= q[0].acc + 1);
         chk("out_valid", {31'd0, o_out_valid}, {31'd0, exp_vld});
         chk("in_ready", {31'd0, o_in_ready}, {31'd0, (q.size() < 2) || i_out_ready});
         if (exp_vld && o_out_valid) begin
            chk("data_out", {16'd0, o_data_out}, {16'd0, q[0].dat});
            chk("ovf", {31'd0, o_ovf}, {31'd0, q[0].ovf});
         end
         chk("sticky", {31'd0, o_ovf_sticky}, {31'd0, m_sticky});
         chk("count", {24'd0, o_ovf_count}, 32'(m_count));
         fired = 1'b0;
         fired_ovf = 1'b0;
         if (o_out_valid && i_out_ready && q.size() > 0) begin
            f = q.pop_front();
            fired = 1'b1;
            fired_ovf = f.ovf;
            obs.push_back({o_ovf, o_data_out});
            out_edges.push_back(edge_cnt + 1);
         end
         if (i_clear_stats) begin
            m_sticky = 1'b0;
            m_count  = 0;
         end else if (fired && fired_ovf) begin
            m_sticky = 1'b1;
            if (m_count != 255) m_count = m_count + 1;
         end
         if (i_in_valid && o_in_ready) begin
            mr = model(i_data_in, i_mode);
            f.dat = mr[15:0];
            f.ovf = mr[16];
            f.acc = edge_cnt + 1;
            q.push_back(f);
            in_edges.push_back(edge_cnt + 1);
            in_fires++;
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic m);
      logic acc;
      int   t;
      i_in_valid = 1'b1;
      i_data_in  = d;
      i_mode     = m;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 200) begin
         @(negedge clk);
         acc = o_in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      i_in_valid = 1'b0;
      if (!acc) chk("send_timeout", {31'd0, acc}, 32'd1);
   endtask

   task automatic drain();
      int t;
      i_out_ready = 1'b1;
      t = 0;
      while (q.size() > 0 && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   logic [31:0] vd [9] = '{32'h0000_1234, 32'hFFFF_8000, 32'hFFFF_FFFF, 32'h0000_7FFF,
                           32'h0000_8000, 32'hFFFF_7FFF, 32'h8000_0000, 32'h0001_2345,
                           32'h0000_0001};
   logic        vm [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [16:0] ve [9] = '{17'h0_1234, 17'h0_8000, 17'h0_FFFF, 17'h0_7FFF,
                           17'h1_7FFF, 17'h1_8000, 17'h1_8000, 17'h1_2345,
                           17'h0_0001};

   int base;
   int n0;
   int t;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("in_ready_after_reset", {31'd0, o_in_ready}, 32'd1);

      for (int i = 0; i < 9; i++) chk($sformatf("model_vec%0d", i), {15'd0, model(vd[i], vm[i])}, {15'd0, ve[i]});

      obs.delete();
      for (int i = 0; i < 7; i++) send(vd[i], vm[i]);
      drain();
      chk("sticky_after_sat", {31'd0, o_ovf_sticky}, 32'd1);
      chk("count_after_sat", {24'd0, o_ovf_count}, 32'd3);
      for (int i = 7; i < 9; i++) send(vd[i], vm[i]);
      drain();
      chk("directed_obs_count", 32'(obs.size()), 32'd9);
      for (int i = 0; i < 9 && i < obs.size(); i++) chk($sformatf("directed_out%0d", i), {15'd0, obs[i]}, {15'd0, ve[i]});

      // Streaming: one word per clock after a two-edge fill.
      n0 = in_edges.size();
      base = out_edges.size();
      for (int i = 0; i < 16; i++) send(32'(i * 4099) - 32'd30000, i[0]);
      drain();
      chk("stream_outputs", 32'(out_edges.size() - base), 32'd16);
      if (out_edges.size() - base == 16) begin
         chk("stream_first_latency", 32'(out_edges[base] - in_edges[n0]), 32'd2);
         chk("stream_span", 32'(out_edges[base + 15] - out_edges[base]), 32'd15);
      end

      // Backpressure: blocked output holds exactly two words.
      i_out_ready = 1'b0;
      base = in_fires;
      n0 = obs.size();
      fork
         begin
            for (int i = 0; i < 7; i++) send(32'h0000_0100 + 32'(i), 1'b0);
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            chk("stall_accepts", 32'(in_fires - base), 32'd2);
            chk("stall_in_ready", {31'd0, o_in_ready}, 32'd0);
            i_out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_outputs", 32'(obs.size() - n0), 32'd7);
      for (int i = 0; i < 7 && n0 + i < obs.size(); i++)
         chk($sformatf("stall_order%0d", i), {15'd0, obs[n0 + i]}, {15'd0, 1'b0, 16'h0100 + 16'(i)});

      for (int i = 0; i < 300; i++) send(32'h0001_0000 + 32'(i), i[0]);
      drain();
      chk("count_saturated", {24'd0, o_ovf_count}, 32'd255);
      chk("sticky_saturated", {31'd0, o_ovf_sticky}, 32'd1);

      i_clear_stats = 1'b1;
      @(posedge clk);
      #1;
      i_clear_stats = 1'b0;
      chk("clear_count", {24'd0, o_ovf_count}, 32'd0);
      chk("clear_sticky", {31'd0, o_ovf_sticky}, 32'd0);

      // Clear coincides with an overflow transfer: clear must win.
      i_out_ready = 1'b0;
      send(32'h7000_0000, 1'b0);
      t = 0;
      while (!o_out_valid && t < 10) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("clr_word_valid", {31'd0, o_out_valid}, 32'd1);
      chk("clr_word_ovf", {31'd0, o_ovf}, 32'd1);
      i_out_ready   = 1'b1;
      i_clear_stats = 1'b1;
      @(posedge clk);
      #1;
      i_clear_stats = 1'b0;
      chk("clr_prio_count", {24'd0, o_ovf_count}, 32'd0);
      chk("clr_prio_sticky", {31'd0, o_ovf_sticky}, 32'd0);
      chk("clr_word_gone", {31'd0, o_out_valid}, 32'd0);

      // Reset mid-stream drops everything in flight immediately.
      for (int i = 0; i < 3; i++) begin
         i_in_valid = 1'b1;
         i_data_in  = 32'h0000_0A00 + 32'(i);
         i_mode     = 1'b0;
         @(posedge clk);
         #1;
      end
      chk("pre_reset_valid", {31'd0, o_out_valid}, 32'd1);
      i_in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("reset_out_valid", {31'd0, o_out_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("in_ready_after_rst2", {31'd0, o_in_ready}, 32'd1);
      n0 = obs.size();
      send(32'hFFFF_FFFE, 1'b0);
      send(32'h0002_0000, 1'b0);
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("post_reset_outputs", 32'(obs.size() - n0), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
